// File: rtl/block_collision_pkg.sv
// Shared board geometry and FSM encoding for the block-collision logic.
// The renderer imports the same constants so drawn and collided blocks agree.
package block_collision_pkg;

    localparam logic [10:0] X0        = 11'd100;
    localparam logic [10:0] X_PITCH   = 11'd160;
    localparam logic [10:0] Y0        = 11'd60;
    localparam logic [10:0] Y_PITCH   = 11'd70;
    localparam logic [10:0] B_WIDTH   = 11'd100;
    localparam logic [10:0] B_HEIGHT  = 11'd50;
    localparam logic [10:0] BALL_SIZE = 11'd10;
    localparam logic [10:0] BALL_HALF = BALL_SIZE >> 1;

    // Left edge of each block column
    localparam logic [10:0] HOR1 = X0;
    localparam logic [10:0] HOR2 = HOR1 + X_PITCH;
    localparam logic [10:0] HOR3 = HOR2 + X_PITCH;
    localparam logic [10:0] HOR4 = HOR3 + X_PITCH;

    // Top edge of each block row
    localparam logic [10:0] VER1 = Y0;
    localparam logic [10:0] VER2 = VER1 + Y_PITCH;
    localparam logic [10:0] VER3 = VER2 + Y_PITCH;
    localparam logic [10:0] VER4 = VER3 + Y_PITCH;

    localparam logic [3:0]  LAST_IDX = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/block_geom.sv
// Block geometry lookup: block index -> top-left corner, then a ball/block
// overlap test and a check whether the ball centre lies within the block's
// horizontal span (used to choose a vertical versus horizontal bounce).
module block_geom
    import block_collision_pkg::*;
(
    input  logic [3:0]  idx_i,
    input  logic [10:0] ball_x_i,
    input  logic [10:0] ball_y_i,
    output logic        overlap_o,
    output logic        cx_inside_o
);

    logic [10:0] bx0;
    logic [10:0] by0;
    logic [10:0] bx_end;
    logic [10:0] by_end;
    logic [10:0] ball_x_end;
    logic [10:0] ball_y_end;
    logic [10:0] cx;

    // Column/row to edge lookup from the shared constant tables
    always_comb begin
        bx0 = HOR1;
        by0 = VER1;
        case (idx_i[1:0])
            2'd0:    bx0 = HOR1;
            2'd1:    bx0 = HOR2;
            2'd2:    bx0 = HOR3;
            default: bx0 = HOR4;
        endcase
        case (idx_i[3:2])
            2'd0:    by0 = VER1;
            2'd1:    by0 = VER2;
            2'd2:    by0 = VER3;
            default: by0 = VER4;
        endcase
    end

    // Inclusive-range overlap of ball square and block rectangle
    always_comb begin
        bx_end      = bx0 + B_WIDTH;
        by_end      = by0 + B_HEIGHT;
        ball_x_end  = ball_x_i + BALL_SIZE - 11'd1;
        ball_y_end  = ball_y_i + BALL_SIZE - 11'd1;
        cx          = ball_x_i + BALL_HALF;
        overlap_o   = (ball_x_i <= bx_end) && (ball_x_end >= bx0) &&
                      (ball_y_i <= by_end) && (ball_y_end >= by0);
        cx_inside_o = (cx >= bx0) && (cx <= bx_end);
    end

endmodule

// File: rtl/block_collision.sv
// Per-frame ball/block collision: latches the ball on frame_tick, scans the
// 16 blocks one per clock, destroys at most one block and pulses a bounce.
module block_collision
    import block_collision_pkg::*;
(
    input  logic        pclk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        level_clear,
    input  logic [10:0] ball_x,
    input  logic [10:0] ball_y,
    output logic [15:0] blocks_out,
    output logic        hit,
    output logic        flip_x,
    output logic        flip_y,
    output logic        busy,
    output logic        all_cleared
);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [10:0] ball_x_q;
    logic [10:0] ball_y_q;
    logic        pend_q;
    logic [3:0]  pend_idx_q;
    logic        pend_flip_x_q;
    logic [15:0] blocks_q;
    logic        hit_q;
    logic        flip_x_q;
    logic        flip_y_q;
    logic        busy_q;
    logic        all_cleared_q;

    logic        overlap;
    logic        cx_inside;
    logic        candidate_d;

    block_geom u_geom (
        .idx_i       (idx_q),
        .ball_x_i    (ball_x_q),
        .ball_y_i    (ball_y_q),
        .overlap_o   (overlap),
        .cx_inside_o (cx_inside)
    );

    // First live overlapping block of this frame; destroyed blocks are transparent
    always_comb begin
        candidate_d = (state_q == SCAN) && overlap && !blocks_q[idx_q] && !pend_q;
    end

    // Scan FSM with registered mask, pulses and status
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            ball_x_q      <= 11'd0;
            ball_y_q      <= 11'd0;
            pend_q        <= 1'b0;
            pend_idx_q    <= 4'd0;
            pend_flip_x_q <= 1'b0;
            blocks_q      <= 16'h0000;
            hit_q         <= 1'b0;
            flip_x_q      <= 1'b0;
            flip_y_q      <= 1'b0;
            busy_q        <= 1'b0;
            all_cleared_q <= 1'b0;
        end else begin
            hit_q         <= 1'b0;
            flip_x_q      <= 1'b0;
            flip_y_q      <= 1'b0;
            all_cleared_q <= (blocks_q == 16'hFFFF);
            if (level_clear) begin
                state_q  <= IDLE;
                idx_q    <= 4'd0;
                pend_q   <= 1'b0;
                blocks_q <= 16'h0000;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (frame_tick) begin
                            ball_x_q <= ball_x;
                            ball_y_q <= ball_y;
                            idx_q    <= 4'd0;
                            pend_q   <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (candidate_d) begin
                            pend_q        <= 1'b1;
                            pend_idx_q    <= idx_q;
                            pend_flip_x_q <= !cx_inside;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= REPORT;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                    REPORT: begin
                        if (pend_q) begin
                            blocks_q[pend_idx_q] <= 1'b1;
                            hit_q                <= 1'b1;
                            flip_x_q             <= pend_flip_x_q;
                            flip_y_q             <= !pend_flip_x_q;
                        end
                        pend_q  <= 1'b0;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign blocks_out  = blocks_q;
    assign hit         = hit_q;
    assign flip_x      = flip_x_q;
    assign flip_y      = flip_y_q;
    assign busy        = busy_q;
    assign all_cleared = all_cleared_q;

endmodule

// File: doc/block_collision.md
Name: block_collision

Overview:
- Produces the 16-bit destroyed-block mask consumed by the board renderer (bit = 1 → block destroyed, not drawn).
- Once per frame, on a frame tick, latches the ball position and scans the 4x4 block grid sequentially, one block per clock.
- Marks at most one block destroyed per frame and emits one-cycle bounce pulses to the ball-motion logic.
- Sits between the ball controller and the board drawing stage in the pclk domain.

Parameters:
- X0, 100: x of left edge, column 0.
- X_PITCH, 160: horizontal distance between block left edges.
- Y0, 60: y of top edge, row 0.
- Y_PITCH, 70: vertical distance between block top edges.
- B_WIDTH, 100: block spans x .. x+B_WIDTH inclusive.
- B_HEIGHT, 50: block spans y .. y+B_HEIGHT inclusive.
- BALL_SIZE, 10: ball is a square spanning bx .. bx+BALL_SIZE-1, by .. by+BALL_SIZE-1.

Ports:
- pclk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- level_clear  in  1  synchronous; restores all blocks
- ball_x  in  11  ball left edge
- ball_y  in  11  ball top edge
- blocks_out  out  16  destroyed mask; bit i = row*4+col (bit 0 = row 0 col 0, bit 3 = row 0 col 3, bit 4 = row 1 col 0)
- hit  out  1  one-cycle pulse: a block was destroyed this frame
- flip_x  out  1  one-cycle pulse with hit: reverse horizontal direction
- flip_y  out  1  one-cycle pulse with hit: reverse vertical direction
- busy  out  1  high while SCAN/REPORT are active
- all_cleared  out  1  registered, high when blocks_out == 16'hFFFF

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is pclk. All logic is clocked on pclk.
- Reset values: blocks_out = 0, hit = flip_x = flip_y = 0, busy = 0, all_cleared = 0, state = IDLE, idx = 0.
- IDLE:
  - When frame_tick is sampled high, latch ball_x/ball_y, set idx = 0, clear the pending-hit register, enter SCAN, set busy = 1.
- SCAN (16 cycles, idx 0..15):
  - Block geometry: col = idx[1:0], row = idx[3:2]; bx0 = X0 + col*X_PITCH; by0 = Y0 + row*Y_PITCH.
  - All geometry arithmetic is 11-bit unsigned. Pitch multiples are constants; no multiplier is inferred.
  - Overlap: ball_x <= bx0+B_WIDTH && ball_x+BALL_SIZE-1 >= bx0, and the same for y.
  - Candidate: overlap && blocks_out[idx] == 0 && no pending hit yet. The first candidate in index order wins; later candidates in the same frame are ignored.
  - On the winner, record pend_idx and direction. Centre cx = ball_x + BALL_SIZE/2.
    - If bx0 <= cx <= bx0+B_WIDTH → flip_y.
    - Otherwise → flip_x.
  - After idx = 15, go to REPORT.
- REPORT (1 cycle):
  - If a hit is pending: set blocks_out[pend_idx], pulse hit plus the selected flip for exactly one cycle.
  - Return to IDLE; busy drops.
- Latency: if frame_tick is sampled at edge k, the hit/flip pulses and the blocks_out update are visible after edge k+17, for one cycle (pulses only). busy is high after edges k..k+16.
- frame_tick while busy: ignored, never queued.
- Destroyed blocks never collide; the ball passes through them.
- all_cleared is registered from blocks_out and lags it by one cycle. The mask saturates at FFFF with no wrap.
- level_clear:
  - Priority is reset > level_clear > FSM.
  - Sets blocks_out = 0, drops any pending hit with no pulses, and forces IDLE.
  - Works from any state, including mid-SCAN.
- hit, flip_x and flip_y are never high outside REPORT. flip_x and flip_y are mutually exclusive.

Decomposition:
- Shared package/include holds the grid constants X0, X_PITCH, Y0, Y_PITCH, B_WIDTH, B_HEIGHT, BALL_SIZE, and the derived per-column/per-row edges HOR1..HOR4 and VER1..VER4. The renderer and this block use the same source, so geometry cannot diverge.
- Same package: FSM state encoding IDLE/SCAN/REPORT.
- One natural sub-module, block_geom: combinational idx → (bx0, by0) lookup plus the overlap test. It can be reused by any future block renderer.

Test Plan:
- Reset held 3 cycles, then released → blocks_out = 0, hit/flip_x/flip_y/busy/all_cleared = 0.
- Top/bottom face hit: ball (150,105), frame_tick → 17 cycles later hit = 1 and flip_y = 1 for one cycle, flip_x = 0, blocks_out = 16'h0001.
- Side hit on block 5 (x 260..360, y 130..180): ball (358,150), centre x 363 → flip_x = 1, flip_y = 0, blocks_out = 16'h0020.
- Destroyed block and busy: repeat ball (150,105) with bit 0 already set → no hit, mask unchanged. frame_tick re-pulsed 5 cycles into SCAN → ignored, only one REPORT.
- Clear all: force 16 hits across frames → blocks_out = 16'hFFFF, all_cleared = 1 one cycle later. A further overlap produces no hit.
- level_clear mid-scan: pulse level_clear at SCAN idx 3 while a hit on block 1 is pending → blocks_out = 0, busy = 0 next cycle, no hit pulse.
